// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline run-control sequencer and the debug
// unit that drives it: debug command codes, the sequencer state encoding and
// a small helper that says whether a state lets the pipeline advance.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Debug command codes carried on cmd_code
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  // Sequencer run-control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

  // The pipeline moves forward only while running freely or during a single step
  function automatic logic is_advance(input seq_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one on each enabled clock and sticks at its
// all-ones value instead of wrapping.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low clear
//   i_en     in   count enable
//   o_count  out  current count (WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, holding once every bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
// Run-control sequencer for the five-stage MIPS pipeline. Merges debug
// commands, hazard-unit stall/flush requests and HALT detection in decode
// into per-stage register enables and the ID/EX bubble control. After HALT
// is captured the front end freezes while the back end drains the older
// instructions, then the sequencer parks in DONE until reset.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_code         debug command offer (NOP/RUN/STEP/PAUSE)
//   cmd_ready                  command accepted when valid & ready
//   halt_ID                    HALT opcode sits in ID this cycle
//   stall_hz, flush_hz         hazard-unit front-end stall, ID/EX flush
//   en_pc, en_ifid             front-end register enables
//   en_idex, en_exmem, en_memwb back-end register enables
//   flush_idex_o               inject bubble into ID/EX
//   running                    state is RUN
//   done                       program fully drained
//   cycle_count                saturating count of advance cycles
// ---------------------------------------------------------------------------
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  output logic             cmd_ready,
  input  logic             halt_ID,
  input  logic             stall_hz,
  input  logic             flush_hz,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_idex_o,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  seq_state_e         r_state;
  seq_state_e         w_nextState;
  logic               r_haltSeen;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic               r_running;
  logic               r_done;

  logic w_advance;
  logic w_cmdAccept;
  logic w_capture;
  logic w_drainLast;
  logic w_frontEn;

  assign w_advance   = is_advance(r_state);
  assign w_cmdAccept = cmd_valid & cmd_ready;

  // A stalled HALT is not captured; it is retried once the stall clears
  assign w_capture   = w_advance & ~r_haltSeen & halt_ID & ~stall_hz;
  assign w_drainLast = w_advance & r_haltSeen & (r_drainCnt == DRAIN_W'(1));

  // Commands can only be taken while idle or running; gated by reset so the
  // debug unit never sees a ready handshake while the sequencer is held
  assign cmd_ready = rst_n & ((r_state == ST_IDLE) | (r_state == ST_RUN));

  // Front end freezes on the HALT decode cycle itself and stays frozen
  assign w_frontEn    = w_advance & ~stall_hz & ~r_haltSeen & ~halt_ID;
  assign en_pc        = w_frontEn;
  assign en_ifid      = w_frontEn;
  assign en_idex      = w_advance;
  assign en_exmem     = w_advance;
  assign en_memwb     = w_advance;
  assign flush_idex_o = w_advance & (flush_hz | r_haltSeen);

  // Next-state selection; finishing the drain overrides every command
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmdAccept && (cmd_code == CMD_RUN)) begin
          w_nextState = ST_RUN;
        end else if (w_cmdAccept && (cmd_code == CMD_STEP)) begin
          w_nextState = ST_STEP;
        end
      end
      ST_RUN: begin
        if (w_cmdAccept && (cmd_code == CMD_PAUSE)) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_STEP: w_nextState = ST_IDLE;
      ST_DONE: w_nextState = ST_DONE;
      default: w_nextState = ST_IDLE;
    endcase
    if (w_drainLast) begin
      w_nextState = ST_DONE;
    end
  end

  // State, registered status outputs and HALT drain bookkeeping. The drain
  // counter only moves on advance cycles so single-stepping through a drain
  // retires one stage per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_haltSeen <= 1'b0;
      r_drainCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_running <= (w_nextState == ST_RUN);
      r_done    <= (w_nextState == ST_DONE);
      if (w_capture) begin
        r_haltSeen <= 1'b1;
        r_drainCnt <= DRAIN_W'(DRAIN_CYCLES);
      end else if (w_advance && r_haltSeen && (r_drainCnt != '0)) begin
        r_drainCnt <= r_drainCnt - DRAIN_W'(1);
      end
    end
  end

  assign running = r_running;
  assign done    = r_done;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycleCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_advance),
    .o_count (cycle_count)
  );

endmodule
